// File: rtl/nlc_pkg.sv
// nlc_pkg
// Shared definitions for the NLC sample buffer slice: ADC sample width,
// default FIFO depth and engine timeout, and the dispatch FSM state encoding.
package nlc_pkg;

  localparam int ADC_W           = 21;
  localparam int DEF_DEPTH       = 8;
  localparam int DEF_TIMEOUT_CYC = 1023;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    GAP   = 2'b11
  } nlcState_t;

endpackage

// File: rtl/nlc_sync_fifo.sv
// nlc_sync_fifo
// Small synchronous FIFO holding ADC samples in front of the NLC engine.
// The head entry stays in place while the engine evaluates it and is only
// popped once the engine finishes (or is abandoned).
//
// Ports:
//   clk        system clock
//   reset      asynchronous active-low reset (pointers and count only)
//   i_push     write i_wrData at the tail (caller guarantees not full)
//   i_wrData   sample to store
//   i_pop      drop the head entry
//   o_rdData   current head entry
//   o_count    occupancy 0..DEPTH
//   o_full     o_count == DEPTH
//   o_empty    o_count == 0
module nlc_sync_fifo
  import nlc_pkg::*;
#(
  parameter int DATA_W = ADC_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_wrData,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_rdData,
  output logic [ADDR_W:0]   o_count,
  output logic              o_full,
  output logic              o_empty
);

  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wrPtr;
  logic [ADDR_W-1:0] r_rdPtr;
  logic [ADDR_W:0]   r_count;
  logic              w_push;
  logic              w_pop;

  // A push into a full FIFO or a pop from an empty one is ignored here, so
  // the pointers and count can never disagree even if the caller misbehaves.
  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  // Storage has no reset; its contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= i_wrData;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; the extra count
  // bit is what tells a full FIFO apart from an empty one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + PTR_ONE;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdData = r_mem[r_rdPtr];
  assign o_count  = r_count;
  assign o_full   = (r_count == FULL_CNT);
  assign o_empty  = (r_count == '0);

endmodule

// File: rtl/nlc_sample_buffer.sv
// nlc_sample_buffer
// Absorbs ADC samples that arrive while the downstream NLC engine is busy and
// hands them to the engine one at a time: a single-cycle nlc_srdyi pulse, then
// nlc_x held stable until the engine answers with nlc_srdyo (or a timeout
// expires). Dropped samples and engine timeouts raise sticky flags.
//
// Ports:
//   clk, reset          clock; asynchronous active-low reset
//   adc_srdyi, adc_x    incoming sample strobe and data
//   nlc_srdyi, nlc_x    dispatch pulse and held sample to the engine
//   nlc_srdyo           engine done
//   fifo_count          occupancy 0..DEPTH, with full/empty decodes
//   overflow, timeout   sticky flags, cleared by clear_flags (set wins)
//   drop_cnt, hwm       only with NLC_BUF_STATS_EN: saturating drop count and
//                       highest occupancy seen, both zeroed by clear_flags
//
// Build option: define NLC_BUF_STATS_EN to add the drop_cnt/hwm statistics.
module nlc_sample_buffer
  import nlc_pkg::*;
#(
  parameter int DATA_W      = ADC_W,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int ADDR_W      = $clog2(DEPTH),
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              adc_srdyi,
  input  logic [DATA_W-1:0] adc_x,
  output logic              nlc_srdyi,
  output logic [DATA_W-1:0] nlc_x,
  input  logic              nlc_srdyo,
  output logic [ADDR_W:0]   fifo_count,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic              timeout,
  input  logic              clear_flags
`ifdef NLC_BUF_STATS_EN
  ,
  output logic [15:0]       drop_cnt,
  output logic [ADDR_W:0]   hwm
`endif
);

  localparam int              TO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

  nlcState_t         r_state;
  logic [DATA_W-1:0] r_x;
  logic              r_srdyi;
  logic [TO_W-1:0]   r_toCnt;
  logic              r_overflow;
  logic              r_timeout;

  logic              w_push;
  logic              w_drop;
  logic              w_pop;
  logic              w_toHit;
  logic              w_toEvent;
  logic [DATA_W-1:0] w_head;
  logic [ADDR_W:0]   w_count;
  logic              w_full;
  logic              w_empty;

  // Admission is decided on the registered full flag, so a sample arriving
  // on the same edge as a pop from a full FIFO is still dropped.
  assign w_push = adc_srdyi & ~w_full;
  assign w_drop = adc_srdyi & w_full;

  // The in-flight sample leaves the FIFO only when the engine is done with
  // it or has been given up on; until then it still occupies its slot.
  assign w_toHit   = (r_toCnt == TO_LAST);
  assign w_pop     = (r_state == WAIT) & (nlc_srdyo | w_toHit);
  assign w_toEvent = (r_state == WAIT) & ~nlc_srdyo & w_toHit;

  nlc_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .i_push   (w_push),
    .i_wrData (adc_x),
    .i_pop    (w_pop),
    .o_rdData (w_head),
    .o_count  (w_count),
    .o_full   (w_full),
    .o_empty  (w_empty)
  );

  // Dispatch FSM. nlc_x is loaded only on IDLE->ISSUE and otherwise held,
  // which keeps it stable through ISSUE, WAIT and GAP. The timeout counter
  // starts from zero on the first WAIT cycle, so a silent engine gets exactly
  // TIMEOUT_CYC WAIT cycles before the sample is abandoned. GAP lets the
  // engine drop srdyo before anything new is issued.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_x     <= '0;
      r_srdyi <= 1'b0;
      r_toCnt <= '0;
    end else begin
      r_srdyi <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            r_x     <= w_head;
            r_srdyi <= 1'b1;
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          r_toCnt <= '0;
          r_state <= WAIT;
        end
        WAIT: begin
          if (nlc_srdyo || w_toHit) begin
            r_state <= GAP;
          end else begin
            r_toCnt <= r_toCnt + TO_ONE;
          end
        end
        GAP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Sticky flags: a new event in the same cycle as clear_flags keeps the
  // flag set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_overflow <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_overflow <= w_drop | (r_overflow & ~clear_flags);
      r_timeout  <= w_toEvent | (r_timeout & ~clear_flags);
    end
  end

`ifdef NLC_BUF_STATS_EN
  logic [15:0]     r_dropCnt;
  logic [ADDR_W:0] r_hwm;

  // Drop counter saturates at all-ones; a drop during clear_flags restarts
  // it at one so the event is not lost. The high-water mark follows the
  // registered occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dropCnt <= '0;
      r_hwm     <= '0;
    end else begin
      if (clear_flags) begin
        r_dropCnt <= {15'd0, w_drop};
        r_hwm     <= '0;
      end else begin
        if (w_drop && (r_dropCnt != 16'hFFFF)) begin
          r_dropCnt <= r_dropCnt + 16'd1;
        end
        if (w_count > r_hwm) begin
          r_hwm <= w_count;
        end
      end
    end
  end

  assign drop_cnt = r_dropCnt;
  assign hwm      = r_hwm;
`endif

  assign nlc_srdyi  = r_srdyi;
  assign nlc_x      = r_x;
  assign fifo_count = w_count;
  assign full       = w_full;
  assign empty      = w_empty;
  assign overflow   = r_overflow;
  assign timeout    = r_timeout;

endmodule

// File: tb/tb_nlc_sample_buffer.sv
// tb_nlc_sample_buffer
// Directed bench for nlc_sample_buffer. dutA uses the default timeout and a
// behavioural engine with programmable latency; dutB uses TIMEOUT_CYC=16 and
// an engine that never answers.
module tb_nlc_sample_buffer;

  logic        clk = 1'b0;
  logic        reset;

  logic        adcSrdyi;
  logic [20:0] adcX;
  logic        nlcSrdyi;
  logic [20:0] nlcX;
  logic        nlcSrdyo;
  logic [3:0]  fifoCount;
  logic        full;
  logic        empty;
  logic        overflow;
  logic        timeoutFlag;
  logic        clearFlags;

  logic        bAdcSrdyi;
  logic [20:0] bAdcX;
  logic        bNlcSrdyi;
  logic [20:0] bNlcX;
  logic        bNlcSrdyo;
  logic [3:0]  bFifoCount;
  logic        bFull;
  logic        bEmpty;
  logic        bOverflow;
  logic        bTimeout;
  logic        bClearFlags;

`ifdef NLC_BUF_STATS_EN
  logic [15:0] dropCnt;
  logic [3:0]  hwm;
  logic [15:0] bDropCnt;
  logic [3:0]  bHwm;
`endif

  int          errCount   = 0;
  int          checkCount = 0;
  int          engLat     = 40;
  logic [20:0] dispQ[$];
  logic [20:0] expQ[$];
  logic        found;

  // 100 MHz-style clock, active edge is posedge
  always #5 clk = ~clk;

  nlc_sample_buffer dutA (
    .clk         (clk),
    .reset       (reset),
    .adc_srdyi   (adcSrdyi),
    .adc_x       (adcX),
    .nlc_srdyi   (nlcSrdyi),
    .nlc_x       (nlcX),
    .nlc_srdyo   (nlcSrdyo),
    .fifo_count  (fifoCount),
    .full        (full),
    .empty       (empty),
    .overflow    (overflow),
    .timeout     (timeoutFlag),
    .clear_flags (clearFlags)
`ifdef NLC_BUF_STATS_EN
    ,
    .drop_cnt    (dropCnt),
    .hwm         (hwm)
`endif
  );

  nlc_sample_buffer #(.TIMEOUT_CYC(16)) dutB (
    .clk         (clk),
    .reset       (reset),
    .adc_srdyi   (bAdcSrdyi),
    .adc_x       (bAdcX),
    .nlc_srdyi   (bNlcSrdyi),
    .nlc_x       (bNlcX),
    .nlc_srdyo   (bNlcSrdyo),
    .fifo_count  (bFifoCount),
    .full        (bFull),
    .empty       (bEmpty),
    .overflow    (bOverflow),
    .timeout     (bTimeout),
    .clear_flags (bClearFlags)
`ifdef NLC_BUF_STATS_EN
    ,
    .drop_cnt    (bDropCnt),
    .hwm         (bHwm)
`endif
  );

  // Engine model for dutA: records each dispatched sample and answers with a
  // one-cycle srdyo after engLat cycles, all on the falling edge.
  initial begin : engineModel
    nlcSrdyo = 1'b0;
    forever begin
      @(negedge clk);
      if (nlcSrdyi === 1'b1) begin
        dispQ.push_back(nlcX);
        repeat (engLat) @(negedge clk);
        nlcSrdyo = 1'b1;
        @(negedge clk);
        nlcSrdyo = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected)
    else begin
      errCount++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [20:0] x);
    adcSrdyi = 1'b1;
    adcX     = x;
    tick();
    adcSrdyi = 1'b0;
  endtask

  // Steps dutA until it is empty and back in IDLE, bounded by maxCyc.
  task automatic drainA(input string tag, input int maxCyc);
    for (int k = 0; k < maxCyc && !empty; k++) tick();
    checkOutput(tag, {31'd0, empty}, 32'd1);
    tick();
    tick();
  endtask

  // Compares the recorded dispatch order against expQ.
  task automatic checkOrder(input string tag);
    checkOutput({tag, "Size"}, dispQ.size(), expQ.size());
    for (int i = 0; i < expQ.size(); i++) begin
      checkOutput($sformatf("%s[%0d]", tag, i),
                  (i < dispQ.size()) ? {11'd0, dispQ[i]} : 32'hDEAD_BEEF,
                  {11'd0, expQ[i]});
    end
  endtask

  initial begin : mainSeq
    reset       = 1'b0;
    adcSrdyi    = 1'b0;
    adcX        = '0;
    clearFlags  = 1'b0;
    bAdcSrdyi   = 1'b0;
    bAdcX       = '0;
    bNlcSrdyo   = 1'b0;
    bClearFlags = 1'b0;

    // ---- reset state
    #2;
    checkOutput("rstEmpty", {31'd0, empty}, 32'd1);
    checkOutput("rstCount", {28'd0, fifoCount}, 32'd0);
    checkOutput("rstFull", {31'd0, full}, 32'd0);
    checkOutput("rstSrdyi", {31'd0, nlcSrdyi}, 32'd0);
    checkOutput("rstX", {11'd0, nlcX}, 32'd0);
    checkOutput("rstOvf", {31'd0, overflow}, 32'd0);
    checkOutput("rstTo", {31'd0, timeoutFlag}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    tick();

    // ---- single sample, engine latency 40
    $display("[TB] single sample");
    engLat = 40;
    dispQ.delete();
    applyStimulus(21'h000123);
    checkOutput("s1CountN", {28'd0, fifoCount}, 32'd1);
    checkOutput("s1SrdyiN", {31'd0, nlcSrdyi}, 32'd0);
    tick();
    checkOutput("s1SrdyiN1", {31'd0, nlcSrdyi}, 32'd1);
    checkOutput("s1XN1", {11'd0, nlcX}, 32'h123);
    tick();
    checkOutput("s1SrdyiN2", {31'd0, nlcSrdyi}, 32'd0);
    checkOutput("s1XWait", {11'd0, nlcX}, 32'h123);
    repeat (39) tick();
    checkOutput("s1CountLast", {28'd0, fifoCount}, 32'd1);
    tick();
    checkOutput("s1CountPop", {28'd0, fifoCount}, 32'd0);
    checkOutput("s1EmptyPop", {31'd0, empty}, 32'd1);
    checkOutput("s1XGap", {11'd0, nlcX}, 32'h123);
    tick();
    checkOutput("s1XIdle", {11'd0, nlcX}, 32'h123);
    checkOutput("s1SrdyiIdle", {31'd0, nlcSrdyi}, 32'd0);
    expQ = '{21'h000123};
    checkOrder("s1Order");

    // ---- burst of 8 plus one dropped
    $display("[TB] burst");
    engLat = 30;
    dispQ.delete();
    expQ = '{21'h000001, 21'h000002, 21'h000003, 21'h1FFFFF,
             21'h000005, 21'h000006, 21'h000007, 21'h000008};
    for (int i = 0; i < 8; i++) applyStimulus(expQ[i]);
    checkOutput("bstCount8", {28'd0, fifoCount}, 32'd8);
    checkOutput("bstFull8", {31'd0, full}, 32'd1);
    checkOutput("bstOvf8", {31'd0, overflow}, 32'd0);
    applyStimulus(21'h0AAAAA);
    checkOutput("bstCount9", {28'd0, fifoCount}, 32'd8);
    checkOutput("bstOvf9", {31'd0, overflow}, 32'd1);
`ifdef NLC_BUF_STATS_EN
    checkOutput("bstDrop", {16'd0, dropCnt}, 32'd1);
    checkOutput("bstHwm", {28'd0, hwm}, 32'd8);
`endif
    drainA("bstDrain", 1000);
    checkOrder("bstOrder");
    checkOutput("bstOvfHeld", {31'd0, overflow}, 32'd1);
    clearFlags = 1'b1;
    tick();
    clearFlags = 1'b0;
    checkOutput("bstOvfClr", {31'd0, overflow}, 32'd0);
`ifdef NLC_BUF_STATS_EN
    checkOutput("bstDropClr", {16'd0, dropCnt}, 32'd0);
    checkOutput("bstHwmClr", {28'd0, hwm}, 32'd0);
`endif

    // ---- push on the same edge as engine done, count=3
    $display("[TB] simultaneous push/pop");
    engLat = 20;
    dispQ.delete();
    expQ = '{21'h000A01, 21'h1F0002, 21'h000C03, 21'h000D04};
    for (int i = 0; i < 3; i++) applyStimulus(expQ[i]);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (nlcSrdyo) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("simDoneSeen", {31'd0, found}, 32'd1);
    checkOutput("simCountPre", {28'd0, fifoCount}, 32'd3);
    applyStimulus(expQ[3]);
    checkOutput("simCountPost", {28'd0, fifoCount}, 32'd3);
    drainA("simDrain", 500);
    checkOrder("simOrder");

    // ---- timeout on dutB (TIMEOUT_CYC=16, engine silent)
    $display("[TB] timeout");
    bAdcSrdyi = 1'b1;
    bAdcX     = 21'h000055;
    tick();
    bAdcX     = 21'h1ABCDE;
    checkOutput("toCountP", {28'd0, bFifoCount}, 32'd1);
    tick();
    bAdcSrdyi = 1'b0;
    checkOutput("toSrdyi1", {31'd0, bNlcSrdyi}, 32'd1);
    checkOutput("toX1", {11'd0, bNlcX}, 32'h000055);
    checkOutput("toCount2", {28'd0, bFifoCount}, 32'd2);
    repeat (16) tick();
    checkOutput("toFlagPre", {31'd0, bTimeout}, 32'd0);
    checkOutput("toCountPre", {28'd0, bFifoCount}, 32'd2);
    tick();
    checkOutput("toFlagSet", {31'd0, bTimeout}, 32'd1);
    checkOutput("toCountPop", {28'd0, bFifoCount}, 32'd1);
    tick();
    checkOutput("toGapSrdyi", {31'd0, bNlcSrdyi}, 32'd0);
    tick();
    checkOutput("toSrdyi2", {31'd0, bNlcSrdyi}, 32'd1);
    checkOutput("toX2", {11'd0, bNlcX}, 32'h1ABCDE);
    bClearFlags = 1'b1;
    tick();
    bClearFlags = 1'b0;
    checkOutput("toFlagClr", {31'd0, bTimeout}, 32'd0);

    // ---- async reset mid-WAIT with count=5
    $display("[TB] reset mid-wait");
    engLat = 50;
    dispQ.delete();
    for (int i = 0; i < 5; i++) applyStimulus(21'h000010 + 21'(i));
    tick();
    tick();
    checkOutput("rwCount5", {28'd0, fifoCount}, 32'd5);
    checkOutput("rwSrdyiWait", {31'd0, nlcSrdyi}, 32'd0);
    checkOutput("rwXWait", {11'd0, nlcX}, 32'h000010);
    reset = 1'b0;
    #2;
    checkOutput("rwEmpty", {31'd0, empty}, 32'd1);
    checkOutput("rwCount", {28'd0, fifoCount}, 32'd0);
    checkOutput("rwSrdyi", {31'd0, nlcSrdyi}, 32'd0);
    checkOutput("rwX", {11'd0, nlcX}, 32'd0);
    checkOutput("rwOvf", {31'd0, overflow}, 32'd0);
    checkOutput("rwTo", {31'd0, timeoutFlag}, 32'd0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    dispQ.delete();
    repeat (60) tick();
    checkOutput("rwNoDispatch", dispQ.size(), 32'd0);
    checkOutput("rwStillEmpty", {31'd0, empty}, 32'd1);

    // ---- pointer wrap: 20 push/dispatch pairs
    $display("[TB] pointer wrap");
    engLat = 2;
    dispQ.delete();
    expQ.delete();
    for (int i = 0; i < 20; i++) begin
      expQ.push_back(21'h100000 + 21'(i * 37));
      applyStimulus(expQ[i]);
      for (int k = 0; k < 50 && !empty; k++) tick();
    end
    tick();
    tick();
    checkOrder("wrapOrder");
    checkOutput("wrapOvf", {31'd0, overflow}, 32'd0);
    checkOutput("wrapEmpty", {31'd0, empty}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
